// File: rtl/bram_blocks_pingpong.sv
// Ping-pong block store: one dual-port BRAM split into two frame banks, so a
// producer can fill one frame while a consumer drains or replays the other.
module bram_blocks_pingpong #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     write_next_block_valid_in,
  input  logic [REGISTER_SIZE-1:0] write_block_in,
  output logic                     write_ready_out,
  input  logic                     read_next_block_valid_in,
  input  logic                     read_replay_in,
  output logic                     read_ready_out,
  output logic [REGISTER_SIZE-1:0] read_block_out,
  output logic                     read_block_pipe2_valid_out,
  output logic                     read_last_pipe2_out,
  output logic                     read_requested_for_last_block,
  output logic [1:0]               frames_stored_out
);

  localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  // Address is {bank, idx}, so each bank occupies a power-of-two window.
  localparam int DEPTH = 2 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             v1_q, v1_d, v2_q, v2_d;
  logic             last1_q, last1_d, last2_q, last2_d;

  logic [REGISTER_SIZE-1:0] mem [DEPTH];
  logic [REGISTER_SIZE-1:0] rd1_q, rd2_q;

  logic wr_accept, rd_accept, wr_last, rd_last;

  assign wr_accept = write_next_block_valid_in && !full_q[wr_bank_q];
  assign rd_accept = read_next_block_valid_in && full_q[rd_bank_q];
  assign wr_last   = (wr_idx_q == LAST_IDX);
  assign rd_last   = (rd_idx_q == LAST_IDX);

  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    if (wr_accept) begin
      if (wr_last) begin
        wr_idx_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
    // Completion and release always hit opposite banks, so both updates stand.
    if (rd_accept) begin
      if (rd_last) begin
        rd_idx_d = '0;
        if (!read_replay_in) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
        end
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end
    v1_d    = rd_accept;
    last1_d = rd_accept && rd_last;
    v2_d    = v1_q;
    last2_d = last1_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      last1_q   <= 1'b0;
      last2_q   <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      last1_q   <= last1_d;
      last2_q   <= last2_d;
    end
  end

  // BRAM array plus its output register; left unreset so it maps onto block RAM.
  always_ff @(posedge clk_in) begin
    if (wr_accept) begin
      mem[{wr_bank_q, wr_idx_q}] <= write_block_in;
    end
    rd1_q <= mem[{rd_bank_q, rd_idx_q}];
    rd2_q <= rd1_q;
  end

  assign write_ready_out               = !full_q[wr_bank_q];
  assign read_ready_out                = full_q[rd_bank_q];
  assign read_block_out                = rd2_q;
  assign read_block_pipe2_valid_out    = v2_q;
  assign read_last_pipe2_out           = last2_q;
  assign read_requested_for_last_block = rd_last && full_q[rd_bank_q];
  assign frames_stored_out             = {1'b0, full_q[0]} + {1'b0, full_q[1]};

endmodule

// File: tb/tb_bram_blocks_pingpong.sv
// Bench for bram_blocks_pingpong (NUM_BLOCKS=4): a fixed vector table for a
// single frame, then model-checked directed and random sequences.
module tb_bram_blocks_pingpong;
  localparam int NB = 4;

  logic        clk, rst_n;
  logic        wv, rv, rep;
  logic [31:0] wd;
  logic        wr_rdy, rd_rdy, rvalid, rlast, rql;
  logic [31:0] rdata;
  logic [1:0]  fs;

  int checks = 0;
  int failures = 0;
  int ec = 0;

  bram_blocks_pingpong #(.REGISTER_SIZE(32), .NUM_BLOCKS(NB)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .write_next_block_valid_in(wv), .write_block_in(wd), .write_ready_out(wr_rdy),
    .read_next_block_valid_in(rv), .read_replay_in(rep), .read_ready_out(rd_rdy),
    .read_block_out(rdata), .read_block_pipe2_valid_out(rvalid),
    .read_last_pipe2_out(rlast), .read_requested_for_last_block(rql),
    .frames_stored_out(fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic        rv;
    logic        e_wr;
    logic        e_rd;
    logic [1:0]  e_fs;
    logic        e_v;
    logic [31:0] e_d;
    logic        e_last;
    logic        e_rql;
  } vec_t;
  vec_t tbl [10];

  // Reference model: completed frames as a flat word queue, the frame being
  // filled, read position within the oldest frame, and expected read returns.
  typedef struct {
    int          due;
    logic [31:0] data;
    logic        last;
  } pend_t;
  logic [31:0] wq[$];
  logic [31:0] pw[$];
  pend_t       pend[$];
  int          rp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    wq.delete();
    pw.delete();
    pend.delete();
    rp = 0;
  endtask

  task automatic check_outputs();
    bit ev;
    chk("write_ready", 32'(wr_rdy), 32'(wq.size() < 2 * NB));
    chk("read_ready", 32'(rd_rdy), 32'(wq.size() >= NB));
    chk("frames_stored", 32'(fs), 32'(wq.size() / NB));
    chk("req_last", 32'(rql), 32'((rp == NB - 1) && (wq.size() >= NB)));
    ev = (pend.size() > 0) && (pend[0].due == ec);
    chk("valid", 32'(rvalid), 32'(ev));
    if (ev) begin
      chk("data", rdata, pend[0].data);
      chk("last", 32'(rlast), 32'(pend[0].last));
      $display("read word %08h last=%0b", rdata, rlast);
      void'(pend.pop_front());
    end else begin
      chk("last_idle", 32'(rlast), 32'h0);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge state.
  task automatic cycle(input logic w, input logic [31:0] d, input logic r, input logic rr);
    bit w_acc, r_acc;
    wv = w; wd = d; rv = r; rep = rr;
    w_acc = w && (wq.size() < 2 * NB);
    r_acc = r && (wq.size() >= NB);
    @(posedge clk); #1;
    ec++;
    if (r_acc) begin
      pend.push_back('{due: ec + 1, data: wq[rp], last: (rp == NB - 1)});
      if (rp == NB - 1) begin
        rp = 0;
        if (!rr) repeat (NB) void'(wq.pop_front());
      end else begin
        rp++;
      end
    end
    if (w_acc) begin
      pw.push_back(d);
      if (pw.size() == NB) begin
        foreach (pw[i]) wq.push_back(pw[i]);
        pw.delete();
      end
    end
    check_outputs();
  endtask

  task automatic do_reset();
    wv = 1'b0; rv = 1'b0; rep = 1'b0; wd = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_wr_rdy"}, 32'(wr_rdy), 32'h1);
    chk({tag, "_rd_rdy"}, 32'(rd_rdy), 32'h0);
    chk({tag, "_valid"}, 32'(rvalid), 32'h0);
    chk({tag, "_last"}, 32'(rlast), 32'h0);
    chk({tag, "_rql"}, 32'(rql), 32'h0);
    chk({tag, "_fs"}, 32'(fs), 32'h0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,  1'b0, 1'b0};
    tbl[1] = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,  1'b0, 1'b0};
    tbl[2] = '{1'b1, 32'h12, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,  1'b0, 1'b0};
    tbl[3] = '{1'b1, 32'h13, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0,  1'b0, 1'b0};
    tbl[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0,  1'b0, 1'b0};
    tbl[5] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 32'h10, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 32'h11, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h12, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,  1'b0, 1'b0};

    do_reset();
    check_reset_values("reset");

    // Single frame from the vector table
    for (int i = 0; i < 10; i++) begin
      wv = tbl[i].wv; wd = tbl[i].wd; rv = tbl[i].rv; rep = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_wr_rdy", i), 32'(wr_rdy), 32'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_rd_rdy", i), 32'(rd_rdy), 32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_fs", i), 32'(fs), 32'(tbl[i].e_fs));
      chk($sformatf("tbl%0d_valid", i), 32'(rvalid), 32'(tbl[i].e_v));
      chk($sformatf("tbl%0d_last", i), 32'(rlast), 32'(tbl[i].e_last));
      chk($sformatf("tbl%0d_rql", i), 32'(rql), 32'(tbl[i].e_rql));
      if (tbl[i].e_v) chk($sformatf("tbl%0d_data", i), rdata, tbl[i].e_d);
      $display("vector %0d: valid=%0b data=%08h", i, rvalid, rdata);
    end

    // Backpressure: two full frames, a dropped ninth write, then drain
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
    chk("bp_fs", 32'(fs), 32'h2);
    chk("bp_wr_rdy", 32'(wr_rdy), 32'h0);
    cycle(1'b1, 32'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("bp_fs_end", 32'(fs), 32'h0);

    // Replay: the frame is returned twice and freed only after the second pass
    do_reset();
    for (int i = 0; i < NB; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < NB; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("replay_fs_mid", 32'(fs), 32'h1);
    chk("replay_rd_rdy_mid", 32'(rd_rdy), 32'h1);
    for (int i = 0; i < NB; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("replay_fs_end", 32'(fs), 32'h0);

    // Dropped reads while empty; the first real frame starts at word 0
    do_reset();
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < NB; i++) cycle(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < NB + 3; i++) cycle(1'b0, 32'h0, (i < NB), 1'b0);

    // Async reset with a partial frame and one read in flight
    do_reset();
    for (int i = 0; i < NB; i++) cycle(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'hD0, 1'b0, 1'b0);
    cycle(1'b1, 32'hD1, 1'b1, 1'b0);
    wv = 1'b0; rv = 1'b0; rep = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async");
    model_clear();
    @(posedge clk); #1;
    ec++;
    chk("async_no_valid", 32'(rvalid), 32'h0);
    rst_n = 1'b1;
    repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < NB; i++) cycle(1'b1, 32'hE0 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < NB + 3; i++) cycle(1'b0, 32'h0, (i < NB), 1'b0);

    // Concurrent streaming: full-rate writer/reader, then random mix
    do_reset();
    for (int i = 0; i < 64; i++) cycle(1'b1, 32'h1000 + 32'(i), (i >= NB), 1'b0);
    for (int i = 0; i < 500; i++)
      cycle(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0));
    for (int i = 0; i < 3 * NB + 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_blocks_pingpong.md
# bram_blocks_pingpong

Double-buffered (ping-pong) block store. It replaces the single-bank streaming BRAM buffer wherever a producer (for example a Montgomery or modexp stage) must write frame k+1 while a consumer is still reading frame k. One true-dual-port BRAM of depth 2·NUM_BLOCKS is split into two banks. Each bank holds one frame of NUM_BLOCKS words. Ownership, full/empty tracking and bank swapping happen internally, and a replay mode lets the consumer re-read a frame without the producer rewriting it.

## Interface
- REGISTER_SIZE, 32, word width in bits
- NUM_BLOCKS, 128, words per frame (≥2); BRAM depth = 2·NUM_BLOCKS
- clk_in  input  1  the block's only clock
- rst_n_in  input  1  asynchronous, active-low reset
- write_next_block_valid_in  input  1  write write_block_in to next slot of current write bank
- write_block_in  input  REGISTER_SIZE  write data
- write_ready_out  output  1  current write bank is empty/filling; writes accepted
- read_next_block_valid_in  input  1  request next word of current read bank
- read_replay_in  input  1  sampled only with the last-word read request; 1 = keep bank and wrap to word 0
- read_ready_out  output  1  current read bank holds a complete frame
- read_block_out  output  REGISTER_SIZE  read data, meaningful only when valid
- read_block_pipe2_valid_out  output  1  read_block_out valid (2 cycles after accepted request)
- read_last_pipe2_out  output  1  the word currently on read_block_out is word NUM_BLOCKS-1 of the frame
- read_requested_for_last_block  output  1  unpiped; read address currently points at word NUM_BLOCKS-1 and read_ready_out=1
- frames_stored_out  output  2  number of full banks, 0..2

## Operation
- State: wr_bank, rd_bank (1 bit each), full[1:0], wr_idx, rd_idx (each $clog2(NUM_BLOCKS) bits).
- BRAM port B writes at address {wr_bank, wr_idx}. Port A reads at address {rd_bank, rd_idx}. Port A is read-first with a 2-cycle latency.
- write_ready_out = !full[wr_bank]. An accepted write requires write_next_block_valid_in && write_ready_out.
  - wr_idx increments on each accepted write.
  - On an accepted write with wr_idx = NUM_BLOCKS-1: wr_idx → 0, full[wr_bank] → 1, wr_bank toggles.
- Writes with write_ready_out=0 are dropped. There is no BRAM write and no state change.
- read_ready_out = full[rd_bank]. An accepted read requires read_next_block_valid_in && read_ready_out.
  - rd_idx increments on each accepted read.
  - On an accepted read with rd_idx = NUM_BLOCKS-1 and read_replay_in=0: rd_idx → 0, full[rd_bank] → 0, rd_bank toggles.
  - Same case with read_replay_in=1: rd_idx → 0; bank and full bit are unchanged.
- Reads with read_ready_out=0 are dropped and produce no valid pulse.
- A simultaneous frame completion (set) and frame release (clear) always target different banks and both take effect in the same cycle.
- A write and a read can never target the same bank at the same time, so there is no read/write address collision.
- frames_stored_out = full[0] + full[1].

## Timing
- Reset (asynchronous assert, synchronous deassert expected from system): full=0, wr_bank=rd_bank=0, wr_idx=rd_idx=0, all pipeline valids 0.
- Outputs under reset: write_ready_out=1, read_ready_out=0, read_block_pipe2_valid_out=0, read_last_pipe2_out=0, read_requested_for_last_block=0, frames_stored_out=0.
- Reset mid-operation:
  - In-flight reads are discarded (no valid after reset).
  - Partially written frames are lost.
  - BRAM contents are not cleared.
- Accepted read at edge N: data and read_block_pipe2_valid_out are high during cycle N+2. read_last_pipe2_out is aligned with that valid.
- Back-to-back reads stream one word per cycle, including across a replay wrap and across a bank swap when the other bank is full.
- Frame completed by a write at edge N: full visible in cycle N+1. If the read bank was that bank, read_ready_out rises in N+1 and a read accepted at N+1 returns the newly written data.
- Release at edge N: write_ready_out rises in N+1 if the writer was stalled on that bank.
- write_ready_out, read_ready_out, read_requested_for_last_block and frames_stored_out are functions of registered state only. There is no combinational path from any input.

## Test plan
- Single frame (NUM_BLOCKS=4): write 0x10..0x13, then read 4 back-to-back.
  - Response: read_ready_out rises 1 cycle after the 4th write.
  - Data 0x10..0x13 appears on cycles N+2..N+5.
  - read_last_pipe2_out is high only with 0x13.
  - Afterwards frames_stored_out=0.
- Backpressure: write 8 words (frames A=1..4, B=5..8) with no reads, then attempt a 9th write.
  - Response: frames_stored_out=2 and write_ready_out=0.
  - The 9th write (0xFF) is dropped.
  - Reading 8 words returns 1..8 with no 0xFF.
- Concurrent streaming: the writer continuously fills frames while the reader drains them, one word per cycle on both ports.
  - Response: all data is returned in order and no word is lost or duplicated.
  - Frame completion and release occurring in the same cycle leaves frames_stored_out consistent.
- Replay: fill frame 0xA0..0xA3; read 4 with read_replay_in=1 on the last request, then read 4 with read_replay_in=0.
  - Response: 0xA0..0xA3 is returned twice.
  - The bank is freed only after the second pass.
- Dropped reads: read requests issued while read_ready_out=0.
  - Response: no valid pulses and rd_idx is unchanged.
  - The first real frame then reads from word 0.
- Async reset after 2 writes and with 1 read in flight.
  - Response: all outputs take their reset values immediately and no valid appears 2 cycles later.
  - A subsequent full frame reads back correctly.
